btle_rx_packet_ctrl: RTL and testbench

//  Receive-side sequencer around gfsk_demodulation. It decimates the oversampled IQ stream by gating the demod's
//  iq_valid to one selected sample phase per symbol. It hunts for the 32-bit access address in the demod bit stream,

---
 rtl/btle_rx_pkg.sv | 7 +
 rtl/btle_dewhiten_lfsr.sv | 24 ++
 rtl/btle_rx_packet_ctrl.sv | 137 +++++++++++++
 tb/tb_btle_rx_packet_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/btle_rx_pkg.sv
// btle_rx_pkg: shared types and constants for the BLE receive packet controller
package btle_rx_pkg;
  typedef enum logic [2:0] {IDLE, SEARCH, HEADER, PAYLOAD, DONE} state_t;
  localparam logic [31:0] BLE_ADV_AA = 32'h8E89BED6;
  localparam int WHITEN_TAP = 4;
  localparam int FLUSH_BITS = 2;
endpackage

// File: rtl/btle_dewhiten_lfsr.sv
// btle_dewhiten_lfsr: x^7+x^4+1 whitening sequence generator seeded from the channel index
module btle_dewhiten_lfsr
  import btle_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [5:0] channel_idx,
  input  logic       step,
  output logic       wbit
);
  logic [6:0] w, nx;
  // rotate by one and fold the feedback into the tap position
  always_comb begin
    nx = {w[5:0], w[6]};
    nx[WHITEN_TAP] = w[WHITEN_TAP-1] ^ w[6];
  end
  // seed on access-address match, advance once per consumed bit
  always_ff @(posedge clk or posedge rst)
    if (rst) w <= '0;
    else if (load) w <= {channel_idx[0], channel_idx[1], channel_idx[2], channel_idx[3], channel_idx[4], channel_idx[5], 1'b1};
    else if (step) w <= nx;
  assign wbit = w[6];
endmodule

// File: rtl/btle_rx_packet_ctrl.sv
// btle_rx_packet_ctrl: decimate IQ, find the access address, frame and de-whiten header and PDU octets
module btle_rx_packet_ctrl
  import btle_rx_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int MAX_PDU_OCTETS = 255,
  localparam int PW = $clog2(SAMPLE_PER_SYMBOL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_enable,
  input  logic [PW-1:0] sample_phase,
  input  logic [31:0]   access_address,
  input  logic [5:0]    channel_idx,
  input  logic          dewhiten_en,
  input  logic          iq_valid_in,
  output logic          demod_iq_valid,
  input  logic          bit_in,
  input  logic          bit_valid_in,
  output logic          aa_hit,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic [7:0]    pdu_len,
  output logic          pkt_done,
  output logic          pkt_error,
  output logic          busy
);
  state_t state, state_d;
  logic [PW-1:0] phase_cnt;
  logic [1:0] flush, flush_d;
  logic [30:0] sreg, sreg_d;
  logic [6:0] shreg, shreg_d;
  logic [2:0] bit_cnt, bit_cnt_d;
  logic [7:0] byte_cnt, byte_cnt_d, pdu_len_d, byte_out_d, oct;
  logic [31:0] sreg_sh;
  logic byte_valid_d, pkt_done_d, pkt_error_d, step, wbit;
  btle_dewhiten_lfsr u_lfsr (
    .clk(clk), .rst(rst), .load(aa_hit), .channel_idx(channel_idx), .step(step), .wbit(wbit)
  );
  // sample-phase counter that picks one IQ sample per symbol
  always_ff @(posedge clk or posedge rst)
    if (rst) phase_cnt <= '0;
    else if (!rx_enable) phase_cnt <= '0;
    else if (iq_valid_in) phase_cnt <= phase_cnt + PW'(1);
  assign demod_iq_valid = rx_enable & iq_valid_in & (phase_cnt == sample_phase);
  assign busy = (state == HEADER) || (state == PAYLOAD);
  // next-state, octet assembly and pulse generation; rx_enable low overrides everything
  always_comb begin
    state_d = state;
    flush_d = flush;
    sreg_d = sreg;
    shreg_d = shreg;
    bit_cnt_d = bit_cnt;
    byte_cnt_d = byte_cnt;
    pdu_len_d = pdu_len;
    byte_out_d = byte_out;
    byte_valid_d = 1'b0;
    pkt_done_d = 1'b0;
    pkt_error_d = 1'b0;
    aa_hit = 1'b0;
    step = 1'b0;
    oct = {bit_in ^ (dewhiten_en & wbit), shreg};
    sreg_sh = {bit_in, sreg};
    if (!rx_enable) begin
      state_d = IDLE;
      sreg_d = '0;
    end else begin
      case (state)
        IDLE: begin
          state_d = SEARCH;
          flush_d = 2'(FLUSH_BITS);
        end
        SEARCH: if (bit_valid_in) begin
          if (flush != 2'd0) flush_d = flush - 2'd1;
          else begin
            sreg_d = sreg_sh[31:1];
            if (sreg_sh == access_address) begin
              aa_hit = 1'b1;
              state_d = HEADER;
              bit_cnt_d = '0;
              byte_cnt_d = '0;
            end
          end
        end
        HEADER, PAYLOAD: if (bit_valid_in) begin
          step = 1'b1;
          shreg_d = oct[7:1];
          bit_cnt_d = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_out_d = oct;
            byte_valid_d = 1'b1;
            byte_cnt_d = byte_cnt + 8'd1;
            if (state == HEADER && byte_cnt == 8'd1) begin
              pdu_len_d = oct;
              byte_cnt_d = '0;
              pkt_error_d = 32'(oct) > MAX_PDU_OCTETS;
              state_d = pkt_error_d ? SEARCH : (oct == 8'd0) ? DONE : PAYLOAD;
            end else if (state == PAYLOAD && byte_cnt == pdu_len - 8'd1) state_d = DONE;
          end
        end
        DONE: begin
          pkt_done_d = 1'b1;
          state_d = SEARCH;
          sreg_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      flush <= '0;
      sreg <= '0;
      shreg <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      pdu_len <= '0;
      byte_out <= '0;
      byte_valid <= 1'b0;
      pkt_done <= 1'b0;
      pkt_error <= 1'b0;
    end else begin
      state <= state_d;
      flush <= flush_d;
      sreg <= sreg_d;
      shreg <= shreg_d;
      bit_cnt <= bit_cnt_d;
      byte_cnt <= byte_cnt_d;
      pdu_len <= pdu_len_d;
      byte_out <= byte_out_d;
      byte_valid <= byte_valid_d;
      pkt_done <= pkt_done_d;
      pkt_error <= pkt_error_d;
    end
endmodule

// File: tb/tb_btle_rx_packet_ctrl.sv
// tb_btle_rx_packet_ctrl: directed and randomized packet checks against a behavioural whitening model
module tb_btle_rx_packet_ctrl;
  localparam int SPS = 8;
  localparam int MAXP = 37;
  logic clk = 0, rst = 1, rx_enable = 0, dewhiten_en = 0, iq_valid_in = 0, bit_in = 0, bit_valid_in = 0;
  logic [2:0] sample_phase = 0;
  logic [31:0] access_address = 32'h8E89BED6;
  logic [5:0] channel_idx = 0;
  logic demod_iq_valid, aa_hit, byte_valid, pkt_done, pkt_error, busy;
  logic [7:0] byte_out, pdu_len;
  btle_rx_packet_ctrl #(.SAMPLE_PER_SYMBOL(SPS), .MAX_PDU_OCTETS(MAXP)) dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .sample_phase(sample_phase),
    .access_address(access_address), .channel_idx(channel_idx), .dewhiten_en(dewhiten_en),
    .iq_valid_in(iq_valid_in), .demod_iq_valid(demod_iq_valid), .bit_in(bit_in),
    .bit_valid_in(bit_valid_in), .aa_hit(aa_hit), .byte_out(byte_out), .byte_valid(byte_valid),
    .pdu_len(pdu_len), .pkt_done(pkt_done), .pkt_error(pkt_error), .busy(busy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, n_aa = 0, n_done = 0, n_err = 0;
  int done_cyc = 0, err_cyc = 0, last_byte_cyc = 0;
  logic [7:0] got_q[$], exp_q[$];
  logic [7:0] pl[0:63];
  logic ws[0:1023];
  logic [6:0] w_snap = 0;
  logic hit_prev = 0;
  // output monitor sampling on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (hit_prev) w_snap = dut.u_lfsr.w;
      hit_prev = aa_hit;
      if (aa_hit) n_aa++;
      if (byte_valid) begin got_q.push_back(byte_out); last_byte_cyc = cyc; end
      if (pkt_done) begin n_done++; done_cyc = cyc; end
      if (pkt_error) begin n_err++; err_cyc = cyc; end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // whitening stream as a 7-stage shift register with feedback into stage 0 and stage 4
  task automatic gen_whiten(input logic [5:0] ch, input int n);
    int r[7];
    int fb;
    r[0] = 1;
    for (int k = 1; k < 7; k++) r[k] = int'(ch[6-k]);
    for (int i = 0; i < n; i++) begin
      ws[i] = r[6][0];
      fb = r[6];
      for (int k = 6; k > 0; k--) r[k] = r[k-1];
      r[0] = fb;
      r[4] = r[4] ^ fb;
    end
  endtask
  task automatic send_bit(input logic b);
    @(posedge clk); #1 bit_in = b; bit_valid_in = 1;
    @(posedge clk); #1 bit_valid_in = 0;
  endtask
  task automatic clr();
    n_aa = 0; n_done = 0; n_err = 0;
    got_q.delete(); exp_q.delete();
  endtask
  task automatic fill_pl();
    for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
  endtask
  task automatic send_packet(input logic [7:0] hdr0, input logic [7:0] len, input int n_oct, input bit arm);
    logic [7:0] o;
    if (arm) begin
      rx_enable = 0; @(posedge clk); #1 rx_enable = 1; @(posedge clk); #1;
      send_bit(1'($urandom)); send_bit(1'($urandom));
    end
    for (int i = 0; i < 8; i++) send_bit(i % 2 == 0);
    for (int i = 0; i < 32; i++) send_bit(access_address[i]);
    gen_whiten(channel_idx, 8 * n_oct);
    for (int j = 0; j < n_oct; j++) begin
      o = (j == 0) ? hdr0 : (j == 1) ? len : pl[j-2];
      exp_q.push_back(o);
      for (int i = 0; i < 8; i++) send_bit(o[i] ^ (dewhiten_en & ws[8*j+i]));
    end
  endtask
  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask
  task automatic check_pkt(input string tag, input int e_aa, input int e_done, input int e_err);
    chk({tag, "_aa_hits"}, n_aa, e_aa);
    chk({tag, "_done"}, n_done, e_done);
    chk({tag, "_err"}, n_err, e_err);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_busy"}, busy, 0);
  endtask
  logic [15:0] mask;
  logic [7:0] len, hdr0;
  int ph;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_valid", byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pdu_len", pdu_len, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_done_err", {pkt_done, pkt_error, aa_hit}, 0);
    rst = 0;
    @(posedge clk); #1;
    // sample-phase gating
    for (int t = 0; t < 3; t++) begin
      ph = (t == 0) ? 3 : int'($urandom_range(7));
      sample_phase = 3'(ph);
      rx_enable = (t != 2);
      mask = 0;
      for (int i = 0; i < 16; i++) begin
        iq_valid_in = 1; #1 mask[i] = demod_iq_valid;
        @(posedge clk); #1;
      end
      iq_valid_in = 0;
      chk($sformatf("phase_mask_%0d", t), mask, (t == 2) ? 0 : ((32'd1 << ph) | (32'd1 << (ph + 8))));
      rx_enable = 0; @(posedge clk); #1;
    end
    // basic packet, no whitening
    dewhiten_en = 0; clr();
    pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
    send_packet(8'h02, 8'h03, 5, 1);
    settle();
    check_pkt("basic", 1, 1, 0);
    chk("basic_pdu_len", pdu_len, 3);
    chk("basic_done_timing", done_cyc, last_byte_cyc + 1);
    // empty PDU back to back from SEARCH
    clr();
    send_packet(8'h00, 8'h00, 2, 0);
    settle();
    check_pkt("empty", 1, 1, 0);
    chk("empty_done_timing", done_cyc, last_byte_cyc + 1);
    // oversize length aborts, then maximum length is accepted
    clr(); fill_pl();
    send_packet(8'h41, 8'(MAXP + 1), 2, 0);
    settle();
    check_pkt("oversize", 1, 0, 1);
    chk("oversize_err_timing", err_cyc, last_byte_cyc);
    clr(); fill_pl();
    send_packet(8'h05, 8'(MAXP), MAXP + 2, 0);
    settle();
    check_pkt("maxlen", 1, 1, 0);
    chk("maxlen_pdu_len", pdu_len, MAXP);
    // whitened packet on channel 37
    clr(); fill_pl();
    dewhiten_en = 1; channel_idx = 6'd37;
    send_packet(8'h42, 8'd10, 12, 1);
    settle();
    check_pkt("ch37", 1, 1, 0);
    chk("ch37_lfsr_seed", w_snap, 7'b1010011);
    // random packets
    for (int t = 0; t < 4; t++) begin
      clr(); fill_pl();
      access_address = $urandom;
      channel_idx = 6'($urandom_range(39));
      dewhiten_en = 1'($urandom);
      len = 8'($urandom_range(1, MAXP));
      hdr0 = 8'($urandom);
      send_packet(hdr0, len, int'(len) + 2, 1);
      settle();
      check_pkt($sformatf("rand%0d", t), 1, 1, 0);
      chk($sformatf("rand%0d_pdu_len", t), pdu_len, len);
    end
    // abort mid-payload with a coincident bit, then flush and recover
    access_address = 32'h8E89BED6; dewhiten_en = 0;
    clr(); fill_pl();
    send_packet(8'h10, 8'd10, 5, 1);
    for (int i = 0; i < 7; i++) send_bit(pl[3][i]);
    @(posedge clk); #1 bit_in = pl[3][7]; bit_valid_in = 1; rx_enable = 0;
    @(posedge clk); #1 bit_valid_in = 0;
    settle();
    check_pkt("abort", 1, 0, 0);
    rx_enable = 1; @(posedge clk); #1;
    for (int i = 0; i < 32; i++) send_bit(access_address[i]);
    settle();
    chk("flush_no_hit", n_aa, 1);
    clr(); fill_pl();
    send_packet(8'h20, 8'd7, 9, 0);
    settle();
    check_pkt("recover", 1, 1, 0);
    // access address inside the payload is not matched
    clr();
    pl[0] = 8'h11; pl[1] = 8'hD6; pl[2] = 8'hBE; pl[3] = 8'h89; pl[4] = 8'h8E; pl[5] = 8'h22;
    send_packet(8'h01, 8'd6, 8, 0);
    settle();
    check_pkt("aa_in_pdu", 1, 1, 0);
    // asynchronous reset while a payload octet is being presented
    clr();
    pl[0] = 8'h5A; pl[1] = 8'hC3; pl[2] = 8'h7E;
    send_packet(8'h01, 8'd9, 5, 0);
    chk("pre_rst_byte_valid", byte_valid, 1);
    #1 rst = 1;
    #1;
    chk("arst_byte_valid", byte_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pdu_len", pdu_len, 0);
    chk("arst_byte_out", byte_out, 0);
    chk("arst_pulses", {aa_hit, pkt_done, pkt_error}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    settle();
    chk("arst_no_done", n_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
